hct74245_ba_buf: RTL and testbench
==================================

Name: hct74245_ba_buf

Overview:
- Timing-accurate behavioural model of one 74HCT245 octal bus transceiver, hard-wired for B-to-A transfer.
- When enabled, it drives bus port A from bus port B after modelled propagation delays; when disabled, it releases A to high-Z.
- Used on SPAM-1 tri-state buses wherever a one-way buffer onto a shared bus is needed.
- Adds a clocked bus-contention monitor as a diagnostic only; the clock and reset never alter the datapath.

Parameters:
- PD_TRANS, 15, data propagation delay B->A in ns while enabled.
- PD_OE, 20, output enable and disable delay in ns (nOE edge to A driven or released).
- LOG, 0, when 1 print a $display line on every contention-flag set.

Ports:
- clk input 1 system clock; samples the contention monitor only. Weak pull-down, so it may be left unconnected.
- _reset input 1 asynchronous active-low reset of monitor state. Weak pull-up, so unconnected means deasserted.
- A inout 8 output side of the buffer (tri-state driver).
- B inout 8 input side; never driven by this block (always high-Z from this block).
- nOE input 1 active-low output enable.
- contention output 1 sticky flag: A was fought by another driver while enabled.

Behaviour:
- Structure: wraps a generic transceiver instance named "inner", with direction fixed B->A and parameters PD_OE and PD_TRANS passed through. Benches reference inner.PD_OE and inner.PD_TRANS, so these names are mandatory.
- Units are ns; timescale is 1ns/1ns.
- nOE=0: the driver on A equals B bitwise, including z and x, i.e. 0->0, 1->1, z->z, x->x.
- nOE=1: the driver on A is 8'bz, so other drivers on the A net win.
- nOE x or z: the driver on A is 8'bx.
- B is never driven by this block.
- Delay on a B change while enabled: A follows after PD_TRANS. The delay is inertial: a pulse shorter than PD_TRANS is swallowed, and only the last value is propagated.
- Delay on an nOE edge: the driver changes between data and z after PD_OE.
- Before any delay has elapsed at time 0, the driver is 8'bx.
- The net value seen on A is the Verilog resolution of this driver with any external drivers. There is no internal pull-up or pull-down on A or B.
- Contention monitor: on each posedge clk, if _reset=1, nOE=0, the PD_OE settling time since the last nOE fall has elapsed, and the resolved value of the A net differs from the delayed B value (compared with !==), then set contention=1.
  - contention stays at 1 until reset.
  - _reset=0 clears contention to 0 immediately (asynchronous); the reset value of contention is 0.
  - Reset is edge-independent of clk; reset mid-contention clears the flag and re-arms the monitor.
- The monitor never drives A or B and never changes datapath timing.

Test Plan:
- Inputs x, nOE=1, check at t=2 ns -> net A and net B both 8'bxxxxxxxx; no assertion error.
- nOE=1, A net and B net undriven (z), wait 30 ns -> A=8'bzzzzzzzz, B=8'bzzzzzzzz.
- nOE=0, B=8'bzzzzzz10, A undriven, wait 30 ns -> A=8'bzzzzzz10 (bitwise z passthrough).
- nOE=1, external A=8'b10xz10xz, B=8'b11111111, wait 31 ns -> A=8'b10xz10xz, B=8'b11111111; contention=0.
- Settle 50 ns with nOE=1, B=8'hFF, A undriven; then nOE=0 -> A becomes 8'b11111111 exactly PD_OE ns later and not earlier. Then set B=8'b10101010 -> A becomes 8'b10101010 exactly PD_TRANS later.
- nOE=0, B=8'h0F, external driver forces A=8'hF0, clk toggled -> contention=1 on the first posedge after settling; pulse _reset low -> contention=0 immediately.

Source files
------------

// File: rtl/hct74245_ba_buf.sv
// hct74245_ba_buf: 74HCT245 behavioural model hard-wired for B->A transfer,
// with a clocked, diagnostic-only bus-contention monitor on the A side.
`timescale 1ns/1ns
`default_nettype none

module hct74245_ba_buf_dly #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  wire  [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  int unsigned chg_cnt  = 0;
  int unsigned chg_seen = 0;
  time         chg_t    = 0;

  // Self-starting so a value applied at time 0 is still propagated after D.
  always begin
    chg_t   = $time;
    chg_cnt = chg_cnt + 1;
    @(d_i);
  end

  // Inertial: output only updates once the input has held still for D.
  always begin
    wait (chg_cnt != chg_seen);
    do begin
      chg_seen = chg_cnt;
      #(64'(D) - ($time - chg_t));
    end while (chg_cnt != chg_seen);
    q_o = d_i;
  end
endmodule

module hct74245_ba_buf_xcvr #(
  parameter int PD_TRANS = 15,
  parameter int PD_OE    = 20,
  parameter bit A_TO_B   = 1'b0
) (
  inout  wire  [7:0] a_io,
  inout  wire  [7:0] b_io,
  input  wire        noe_i,
  output logic [7:0] src_dly_o,
  output logic       oe_dly_o
);
  wire  [7:0] w_src;
  logic [7:0] w_src_dly;
  logic       w_oe_dly;
  wire        w_en;
  wire  [7:0] w_val;

  assign w_src = (A_TO_B != 1'b0) ? a_io : b_io;

  hct74245_ba_buf_dly #(.W(8), .D(PD_TRANS)) u_trans (
    .d_i (w_src),
    .q_o (w_src_dly)
  );

  hct74245_ba_buf_dly #(.W(1), .D(PD_OE)) u_oe (
    .d_i (noe_i),
    .q_o (w_oe_dly)
  );

  // An unknown enable drives x rather than releasing the bus.
  assign w_en  = (w_oe_dly !== 1'b1);
  assign w_val = (w_oe_dly === 1'b0) ? w_src_dly : 8'bx;

  assign src_dly_o = w_src_dly;
  assign oe_dly_o  = w_oe_dly;

  generate
    if (A_TO_B != 1'b0) begin : g_ab
      assign b_io = w_en ? w_val : 8'bz;
    end else begin : g_ba
      assign a_io = w_en ? w_val : 8'bz;
    end
  endgenerate
endmodule

module hct74245_ba_buf #(
  parameter int PD_TRANS = 15,
  parameter int PD_OE    = 20,
  parameter int LOG      = 0
) (
  input  tri0        clk,
  input  tri1        _reset,
  inout  wire  [7:0] A,
  inout  wire  [7:0] B,
  input  wire        nOE,
  output logic       contention
);
  logic [7:0] w_b_dly;
  logic       w_oe_dly;
  logic       contention_q;
  logic       contention_d;

  hct74245_ba_buf_xcvr #(
    .PD_TRANS (PD_TRANS),
    .PD_OE    (PD_OE),
    .A_TO_B   (1'b0)
  ) inner (
    .a_io      (A),
    .b_io      (B),
    .noe_i     (nOE),
    .src_dly_o (w_b_dly),
    .oe_dly_o  (w_oe_dly)
  );

  // Delayed enable low means PD_OE has elapsed since the last nOE fall.
  always_comb begin
    contention_d = contention_q;
    if ((nOE === 1'b0) && (w_oe_dly === 1'b0) && (A !== w_b_dly))
      contention_d = 1'b1;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      contention_q <= 1'b0;
    end else begin
      contention_q <= contention_d;
      if ((LOG != 0) && contention_d && !contention_q)
        $display("%m: contention flagged on A at %0t", $time);
    end
  end

  assign contention = contention_q;
endmodule

`default_nettype wire

// File: tb/tb_hct74245_ba_buf.sv
// tb_hct74245_ba_buf: directed checks of B->A delays, release, and the contention flag.
`timescale 1ns/1ns
`default_nettype none

module tb_hct74245_ba_buf;
  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n;
  logic       noe;
  logic [7:0] a_drv;
  logic       a_en;
  logic [7:0] b_drv;
  wire  [7:0] A;
  wire  [7:0] B;
  wire        contention;
  int         n_vec = 0;
  int         n_bad = 0;

  assign A = a_en ? a_drv : 8'bz;
  assign B = b_drv;

  always #5 clk = clk_run ? ~clk : 1'b0;

  hct74245_ba_buf dut (
    .clk        (clk),
    ._reset     (rst_n),
    .A          (A),
    .B          (B),
    .nOE        (noe),
    .contention (contention)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    noe   = 1'b1;
    a_en  = 1'b0;
    a_drv = 8'h00;
    b_drv = 8'h00;

    #2;
    chk("reset_flag", {7'd0, contention}, 8'h00);
    #3 rst_n = 1'b1;

    // Disabled: an external driver owns A.
    a_en  = 1'b1;
    a_drv = 8'h5A;
    b_drv = 8'hFF;
    #31;
    chk("off_ext_a", A, 8'h5A);
    chk("off_b", B, 8'hFF);
    chk("off_flag", {7'd0, contention}, 8'h00);

    // Enable latency.
    a_en = 1'b0;
    #50 noe = 1'b0;
    #(dut.inner.PD_OE - 1);
    n_vec++;
    assert (A !== 8'hFF) else begin
      n_bad++;
      $error("FAIL oe_early: observed %b required not %b", A, 8'hFF);
    end
    #2;
    chk("oe_on", A, 8'hFF);

    // Data latency.
    b_drv = 8'hAA;
    #(dut.inner.PD_TRANS - 1);
    chk("trans_early", A, 8'hFF);
    #2;
    chk("trans_on", A, 8'hAA);

    // A 5 ns pulse on B is swallowed; only the final value propagates.
    b_drv = 8'h55;
    #5 b_drv = 8'h33;
    #12;
    chk("inertial_hold", A, 8'hAA);
    #5;
    chk("inertial_last", A, 8'h33);

    // Disable latency, then release lets an external driver win.
    noe = 1'b1;
    #(dut.inner.PD_OE - 1);
    chk("oe_off_early", A, 8'h33);
    #2;
    a_en  = 1'b1;
    a_drv = 8'hC3;
    #1;
    chk("released", A, 8'hC3);
    a_en = 1'b0;

    // Contention monitor.
    noe     = 1'b0;
    b_drv   = 8'h0F;
    clk_run = 1'b1;
    repeat (4) @(negedge clk);
    chk("clean_flag", {7'd0, contention}, 8'h00);
    chk("clean_a", A, 8'h0F);

    a_drv = 8'hF0;
    a_en  = 1'b1;
    @(negedge clk);
    chk("fight_flag", {7'd0, contention}, 8'h01);
    @(negedge clk);
    chk("sticky_flag", {7'd0, contention}, 8'h01);

    #1 rst_n = 1'b0;
    #1;
    chk("async_clear", {7'd0, contention}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rearm_flag", {7'd0, contention}, 8'h01);

    a_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("quiet_flag", {7'd0, contention}, 8'h00);
    chk("quiet_a", A, 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
